// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end and the ALU itself:
// control codes, MIPS opcode/funct values and the issue FSM encoding.
package alu_pkg;

  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b0001;
  localparam logic [3:0] ALU_SRA = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b1101;
  localparam logic [3:0] ALU_NOR = 4'b1110;
  localparam logic [3:0] ALU_XOR = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational translation of a MIPS instruction plus its register operands
// into ALU control code, operands, shift amount and destination register.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [3:0]  ctrl,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  shamt,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_rs_field;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // The rs register number is already resolved into rs_data upstream.
  assign unused_rs_field = ^instr[25:21];

  always_comb begin
    ctrl    = ALU_ADD;
    a       = rs_data;
    b       = rt_data;
    shamt   = 5'd0;
    rd      = instr[15:11];
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl = ALU_SUB;
          FN_AND:          ctrl = ALU_AND;
          FN_OR:           ctrl = ALU_OR;
          FN_XOR:          ctrl = ALU_XOR;
          FN_NOR:          ctrl = ALU_NOR;
          FN_SLT:          ctrl = ALU_SLT;
          FN_SLL, FN_SRL, FN_SRA,
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            // Shifts operate on rt; the variable forms take the count from rs.
            a     = rt_data;
            b     = 32'd0;
            shamt = funct[2] ? rs_data[4:0] : instr[10:6];
            case (funct[1:0])
              2'b00:   ctrl = ALU_SLL;
              2'b10:   ctrl = ALU_SRL;
              default: ctrl = ALU_SRA;
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl = ALU_ADD;
        b    = sign_ext16(imm);
        rd   = instr[20:16];
      end
      OP_SLTI: begin
        ctrl = ALU_SLT;
        b    = sign_ext16(imm);
        rd   = instr[20:16];
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR : ALU_XOR;
        b    = zero_ext16(imm);
        rd   = instr[20:16];
      end
      OP_LUI: begin
        ctrl  = ALU_SLL;
        a     = zero_ext16(imm);
        b     = 32'd0;
        shamt = 5'd16;
        rd    = instr[20:16];
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctrl  = ALU_ADD;
      a     = 32'd0;
      b     = 32'd0;
      shamt = 5'd0;
      rd    = 5'd0;
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the combinational ALU: accepts an instruction, drives the
// ALU from registered controls for one cycle, then holds the registered result.
module alu_issue_unit
  import alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic [31:0] o_alu_A,
  output logic [31:0] o_alu_B,
  output logic [4:0]  o_alu_shamt,
  output logic [3:0]  o_alu_ctrl,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_zero,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic [4:0]  o_rd,
  output logic        o_illegal
);

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_shamt;
  logic [4:0]  dec_rd;
  logic        dec_illegal;
  logic [4:0]  rd_q;
  logic        illegal_q;

  alu_decode u_decode (
    .instr   (i_instr),
    .rs_data (i_rs_data),
    .rt_data (i_rt_data),
    .ctrl    (dec_ctrl),
    .a       (dec_a),
    .b       (dec_b),
    .shamt   (dec_shamt),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Ready is held low during reset so nothing is accepted on a reset edge.
  always_comb begin
    next_state = state;
    o_valid    = 1'b0;
    o_ready    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = i_rst_n;
        if (i_valid) next_state = EXEC;
      end
      EXEC: next_state = DONE;
      DONE: begin
        o_valid = 1'b1;
        o_ready = i_rst_n & i_ready;
        if (i_ready) next_state = i_valid ? EXEC : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = i_valid & o_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_alu_ctrl  <= ALU_ADD;
      o_alu_A     <= 32'd0;
      o_alu_B     <= 32'd0;
      o_alu_shamt <= 5'd0;
      rd_q        <= 5'd0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      o_alu_ctrl  <= dec_ctrl;
      o_alu_A     <= dec_a;
      o_alu_B     <= dec_b;
      o_alu_shamt <= dec_shamt;
      rd_q        <= dec_rd;
      illegal_q   <= dec_illegal;
    end
  end

  // Illegal instructions report a zero result with the zero flag cleared.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_result  <= 32'd0;
      o_zero    <= 1'b0;
      o_rd      <= 5'd0;
      o_illegal <= 1'b0;
    end else if (state == EXEC) begin
      o_result  <= illegal_q ? 32'd0 : i_alu_result;
      o_zero    <= illegal_q ? 1'b0 : i_alu_zero;
      o_rd      <= rd_q;
      o_illegal <= illegal_q;
    end
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequencing front end for the single-cycle datapath's combinational ALU. Accepts one decoded-register-read MIPS instruction per valid/ready handshake and translates opcode/funct into the 4-bit ALU control code, operand B and shift amount. Drives the ALU, registers its result and zero flag, and presents them downstream on a valid/ready handshake. It is the producer of the ALU's control interface, while the ALU is the consumer.

## Interface
- No parameters; data width fixed at 32, ALU control width fixed at 4.
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  unit can accept an instruction this cycle
- i_instr  in  32  MIPS instruction word
- i_rs_data  in  32  register-file value of rs
- i_rt_data  in  32  register-file value of rt
- o_alu_A  out  32  ALU operand A
- o_alu_B  out  32  ALU operand B
- o_alu_shamt  out  5  ALU shift amount
- o_alu_ctrl  out  4  ALU control code
- i_alu_result  in  32  ALU result, combinational from o_alu_*
- i_alu_zero  in  1  ALU zero flag
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_result  out  32  registered ALU result
- o_zero  out  1  registered zero flag
- o_rd  out  5  destination register: rd for R-type, rt for I-type
- o_illegal  out  1  instruction not ALU-executable

## Operation
- ALU codes:
  - ADD=1000, SUB=1001
  - AND=1100, OR=1101, NOR=1110, XOR=1111
  - SLL=0000, SRL=0001, SRA=0010
  - SLT=0100
- R-type (opcode 0x00), A=rs, B=rt unless noted:
  - funct 0x20/0x21 ADD; 0x22/0x23 SUB
  - 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: A=rt, shamt=instr[10:6]
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: A=rt, shamt=rs[4:0]
- I-type, A=rs:
  - 0x08/0x09 ADD with B=sign-extended imm
  - 0x0A SLT with B=sign-extended imm
  - 0x0C AND, 0x0D OR, 0x0E XOR with B=zero-extended imm
  - 0x0F (LUI): SLL with A=zero-extended imm, shamt=16
- Non-shift ops drive shamt=0. Shift ops drive B=0.
- Any other opcode/funct is illegal:
  - ALU driven ADD with A=B=0
  - o_result=0, o_zero=0, o_rd=0, o_illegal=1
- FSM states IDLE, EXEC, DONE:
  - IDLE: o_ready=1. On i_valid, register the decoded ctrl/A/B/shamt/rd/illegal, then go to EXEC.
  - EXEC: o_ready=0. ALU is driven from the registered controls. At the clock edge, capture i_alu_result/i_alu_zero into o_result/o_zero, then go to DONE.
  - DONE: o_valid=1. If i_ready and i_valid, accept the new instruction and go to EXEC. If i_ready and !i_valid, go to IDLE. If !i_ready, hold.
- o_ready = (state==IDLE) | (state==DONE & i_ready), forced 0 while i_rst_n=0.
- o_result/o_zero/o_rd/o_illegal are stable from entry to DONE until the handshake completes.
- o_alu_* change only on the accept edge.

## Timing
- Reset (edge with i_rst_n=0) has priority over everything, including a mid-EXEC or mid-DONE transaction, which is discarded.
- Reset values:
  - state IDLE, o_valid=0
  - o_result=0, o_zero=0, o_rd=0, o_illegal=0
  - o_alu_A=0, o_alu_B=0, o_alu_shamt=0, o_alu_ctrl=1000 (ADD, so the ALU never sees an undefined code)
- Latency: accept at edge N; result captured at edge N+1; o_valid high from edge N+1.
- Throughput: one instruction per 2 cycles with i_ready held high and i_valid continuous.
- Back-to-back: the DONE handshake and a new accept in the same cycle are legal. o_valid drops for the EXEC cycle.
- i_instr/i_rs_data/i_rt_data are sampled only on the accept edge. They are don't-care otherwise.

## Structure
- Shared package alu_pkg holds:
  - the ten ALU control codes
  - opcode and funct localparams
  - FSM state encoding
- The ALU imports the same codes.
- Sub-module alu_decode (combinational) maps instr/rs/rt to ctrl, A, B, shamt, rd, illegal.
- alu_issue_unit holds the FSM, the control register stage and the output register stage.

## Test plan
- add rd=3, rs=5, rt=7 → o_result=12, o_zero=0, o_rd=3, o_ctrl=1000. o_valid rises exactly one edge after accept.
- sub with rs=rt=0x00001234 → o_result=0, o_zero=1, o_alu_ctrl=1001.
- addi rt=9, rs=1, imm=0xFFFF → B=0xFFFFFFFF, o_result=0, o_zero=1, o_rd=9. lui imm=0xABCD → o_result=0xABCD0000.
- sllv with rt=1, rs=0x25 → shamt=5, o_result=0x20. sra with shamt field 4 → o_alu_ctrl=0010, o_alu_A=rt.
- opcode 0x23 (lw) → o_illegal=1, o_result=0, o_rd=0, ALU driven ADD/0/0.
- Backpressure: i_ready low 3 cycles in DONE → outputs stable, o_ready=0. A back-to-back accept on the release cycle → EXEC next.
- Reset asserted in DONE → next edge: o_valid=0, state IDLE, o_alu_ctrl=1000.
